ctrl_sequencer: RTL and testbench

CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

---
 rtl/ctrl_sequencer_if.sv | 34 +++
 rtl/ctrl_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_sequencer_if.sv
// Handshake and control-word bundle between an instruction source and ctrl_sequencer.
// The master side presents opcodes; the slave side (the sequencer) returns the control word.
interface ctrl_sequencer_if #(
    parameter int unsigned OPW  = 4,
    parameter int unsigned ALUW = 3,
    parameter int unsigned ECW  = 8
);
    logic            instr_valid;
    logic [OPW-1:0]  opcode;
    logic            instr_ready;
    logic            ctrl_valid;
    logic            RegWrite;
    logic            MemtoReg;
    logic            MemWrite;
    logic            ALUSrc;
    logic            RegDst;
    logic [ALUW-1:0] ALUControl1;
    logic [ALUW-1:0] ALUControl2;
    logic            halted;
    logic            illegal;
    logic [ECW-1:0]  err_cnt;

    modport master (
        output instr_valid, opcode,
        input  instr_ready, ctrl_valid, RegWrite, MemtoReg, MemWrite, ALUSrc, RegDst,
        input  ALUControl1, ALUControl2, halted, illegal, err_cnt
    );

    modport slave (
        input  instr_valid, opcode,
        output instr_ready, ctrl_valid, RegWrite, MemtoReg, MemWrite, ALUSrc, RegDst,
        output ALUControl1, ALUControl2, halted, illegal, err_cnt
    );
endinterface

// File: rtl/ctrl_sequencer.sv
// Control sequencer: decodes opcodes into a registered datapath control word.
// Single-cycle ops produce the word one cycle after acceptance; MUL/MAC stall the
// front end for MUL_LAT cycles; HALT parks the sequencer until reset; undefined
// opcodes act as NOP, pulse illegal and bump a saturating error counter.
module ctrl_sequencer #(
    parameter int unsigned OPW     = 4,
    parameter int unsigned ALUW    = 3,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned ECW     = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    ctrl_sequencer_if.slave bus
);
    // Wide enough to hold MUL_LAT-1.
    localparam int unsigned CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    localparam logic [3:0] OpNop  = 4'h0;
    localparam logic [3:0] OpAdd  = 4'h1;
    localparam logic [3:0] OpMul  = 4'h2;
    localparam logic [3:0] OpSlt  = 4'h3;
    localparam logic [3:0] OpMac  = 4'h4;
    localparam logic [3:0] OpAddi = 4'h9;
    localparam logic [3:0] OpHalt = 4'hB;
    localparam logic [3:0] OpLd   = 4'hE;
    localparam logic [3:0] OpSt   = 4'hF;

    typedef enum logic [1:0] {StRun, StMwait, StHalt} state_e;

    state_e state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ctrl_valid_q, ctrl_valid_d;
    logic            rw_q, rw_d, mtr_q, mtr_d, mw_q, mw_d;
    logic            src_q, src_d, dst_q, dst_d;
    logic [ALUW-1:0] a1_q, a1_d, a2_q, a2_d;
    logic            halted_q, halted_d, illegal_q, illegal_d;
    logic [ECW-1:0]  err_cnt_q, err_cnt_d;

    logic [3:0]     op_lo;
    logic [OPW-1:0] op_hi;
    logic           dec_rw, dec_mtr, dec_mw, dec_src, dec_dst;
    logic [2:0]     dec_a1, dec_a2;
    logic           dec_mul, dec_halt, dec_undef;

    // All-ones means pass/none and must stay all-ones at any ALUW.
    function automatic logic [ALUW-1:0] alu_ext(input logic [2:0] code);
        if (code == 3'b111) begin
            return '1;
        end
        return ALUW'(code);
    endfunction

    assign op_lo = bus.opcode[3:0];
    assign op_hi = bus.opcode >> 4;

    // Opcode decode; anything undefined yields the NOP word.
    always_comb begin
        dec_rw    = 1'b0;
        dec_mtr   = 1'b0;
        dec_mw    = 1'b0;
        dec_src   = 1'b0;
        dec_dst   = 1'b0;
        dec_a1    = 3'b111;
        dec_a2    = 3'b111;
        dec_mul   = 1'b0;
        dec_halt  = 1'b0;
        dec_undef = 1'b0;
        if (|op_hi) begin
            dec_undef = 1'b1;
        end else begin
            case (op_lo)
                OpNop: ;
                OpAdd: begin
                    dec_rw  = 1'b1;
                    dec_a1  = 3'b000;
                    dec_dst = 1'b1;
                end
                OpMul: begin
                    dec_rw  = 1'b1;
                    dec_a1  = 3'b001;
                    dec_dst = 1'b1;
                    dec_mul = 1'b1;
                end
                OpSlt: begin
                    dec_rw  = 1'b1;
                    dec_a1  = 3'b010;
                    dec_dst = 1'b1;
                end
                OpMac: begin
                    dec_rw  = 1'b1;
                    dec_a1  = 3'b001;
                    dec_a2  = 3'b000;
                    dec_dst = 1'b1;
                    dec_mul = 1'b1;
                end
                OpAddi: begin
                    dec_rw  = 1'b1;
                    dec_a1  = 3'b000;
                    dec_src = 1'b1;
                end
                OpHalt: dec_halt = 1'b1;
                OpLd: begin
                    dec_rw  = 1'b1;
                    dec_mtr = 1'b1;
                    dec_a1  = 3'b000;
                    dec_src = 1'b1;
                end
                OpSt: begin
                    dec_mw  = 1'b1;
                    dec_a1  = 3'b000;
                    dec_src = 1'b1;
                end
                default: dec_undef = 1'b1;
            endcase
        end
    end

    // Next state and next control word; write enables drop whenever the word is not valid.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ctrl_valid_d = 1'b0;
        rw_d         = 1'b0;
        mtr_d        = 1'b0;
        mw_d         = 1'b0;
        src_d        = src_q;
        dst_d        = dst_q;
        a1_d         = a1_q;
        a2_d         = a2_q;
        halted_d     = halted_q;
        illegal_d    = 1'b0;
        err_cnt_d    = err_cnt_q;
        unique case (state_q)
            StRun: begin
                if (bus.instr_valid) begin
                    src_d = dec_src;
                    dst_d = dec_dst;
                    a1_d  = alu_ext(dec_a1);
                    a2_d  = alu_ext(dec_a2);
                    if (dec_mul && (MUL_LAT > 1)) begin
                        state_d = StMwait;
                        cnt_d   = CW'(MUL_LAT - 1);
                    end else begin
                        ctrl_valid_d = 1'b1;
                        rw_d         = dec_rw;
                        mtr_d        = dec_mtr;
                        mw_d         = dec_mw;
                    end
                    if (dec_halt) begin
                        state_d  = StHalt;
                        halted_d = 1'b1;
                    end
                    if (dec_undef) begin
                        illegal_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + ECW'(1);
                        end
                    end
                end
            end
            StMwait: begin
                // The final countdown step releases the word and reopens the front end.
                if (cnt_q <= CW'(1)) begin
                    state_d      = StRun;
                    cnt_d        = '0;
                    ctrl_valid_d = 1'b1;
                    rw_d         = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StHalt: ;
            default: state_d = StRun;
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StRun;
            cnt_q        <= '0;
            ctrl_valid_q <= 1'b0;
            rw_q         <= 1'b0;
            mtr_q        <= 1'b0;
            mw_q         <= 1'b0;
            src_q        <= 1'b0;
            dst_q        <= 1'b0;
            a1_q         <= '1;
            a2_q         <= '1;
            halted_q     <= 1'b0;
            illegal_q    <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ctrl_valid_q <= ctrl_valid_d;
            rw_q         <= rw_d;
            mtr_q        <= mtr_d;
            mw_q         <= mw_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            a1_q         <= a1_d;
            a2_q         <= a2_d;
            halted_q     <= halted_d;
            illegal_q    <= illegal_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign bus.instr_ready = (state_q == StRun);
    assign bus.ctrl_valid  = ctrl_valid_q;
    assign bus.RegWrite    = rw_q;
    assign bus.MemtoReg    = mtr_q;
    assign bus.MemWrite    = mw_q;
    assign bus.ALUSrc      = src_q;
    assign bus.RegDst      = dst_q;
    assign bus.ALUControl1 = a1_q;
    assign bus.ALUControl2 = a2_q;
    assign bus.halted      = halted_q;
    assign bus.illegal     = illegal_q;
    assign bus.err_cnt     = err_cnt_q;
endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: dut_a (OPW=5, MUL_LAT=3) and dut_b (OPW=4, MUL_LAT=4)
// share clock and reset. Control words are packed as {cv,RW,MtR,MW,A1,A2,Src,Dst}.
module tb_ctrl_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    ctrl_sequencer_if #(.OPW(5), .ALUW(3), .ECW(8)) bus_a ();
    ctrl_sequencer_if #(.OPW(4), .ALUW(3), .ECW(8)) bus_b ();

    ctrl_sequencer #(.OPW(5), .ALUW(3), .MUL_LAT(3), .ECW(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    ctrl_sequencer #(.OPW(4), .ALUW(3), .MUL_LAT(4), .ECW(8)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    localparam logic [11:0] WRst  = 12'b0_000_111_111_00;
    localparam logic [11:0] WNop  = 12'b1_000_111_111_00;
    localparam logic [11:0] WAdd  = 12'b1_100_000_111_01;
    localparam logic [11:0] WAddi = 12'b1_100_000_111_10;
    localparam logic [11:0] WLd   = 12'b1_110_000_111_10;
    localparam logic [11:0] WSt   = 12'b1_001_000_111_10;
    localparam logic [11:0] WIdle = 12'b0_000_000_111_10;
    localparam logic [11:0] WMac  = 12'b1_100_001_000_01;
    localparam logic [11:0] WMacW = 12'b0_000_001_000_01;
    localparam logic [11:0] WMul  = 12'b1_100_001_111_01;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] word_a();
        return {bus_a.ctrl_valid, bus_a.RegWrite, bus_a.MemtoReg, bus_a.MemWrite,
                bus_a.ALUControl1, bus_a.ALUControl2, bus_a.ALUSrc, bus_a.RegDst};
    endfunction

    function automatic logic [11:0] word_b();
        return {bus_b.ctrl_valid, bus_b.RegWrite, bus_b.MemtoReg, bus_b.MemWrite,
                bus_b.ALUControl1, bus_b.ALUControl2, bus_b.ALUSrc, bus_b.RegDst};
    endfunction

    task automatic drive_a(input logic v, input logic [4:0] op);
        bus_a.instr_valid = v;
        bus_a.opcode      = op;
    endtask

    initial begin
        rst_n = 1'b0;
        drive_a(1'b0, 5'h00);
        bus_b.instr_valid = 1'b0;
        bus_b.opcode      = 4'h0;
        tick();
        tick();
        check_eq("rst_word_a", 32'(word_a()), 32'(WRst));
        check_eq("rst_flags_a", {29'd0, bus_a.halted, bus_a.illegal, bus_a.instr_ready},
                 32'h1);
        check_eq("rst_errcnt_a", 32'(bus_a.err_cnt), 32'd0);
        rst_n = 1'b1;
        check_eq("ready_after_rst", 32'(bus_a.instr_ready), 32'd1);

        // Back-to-back single-cycle ops.
        drive_a(1'b1, 5'h01);
        tick();
        check_eq("b2b_add", 32'(word_a()), 32'(WAdd));
        check_eq("b2b_rdy1", 32'(bus_a.instr_ready), 32'd1);
        drive_a(1'b1, 5'h09);
        tick();
        check_eq("b2b_addi", 32'(word_a()), 32'(WAddi));
        drive_a(1'b1, 5'h0E);
        tick();
        check_eq("b2b_ld", 32'(word_a()), 32'(WLd));
        check_eq("b2b_rdy3", 32'(bus_a.instr_ready), 32'd1);
        drive_a(1'b1, 5'h0F);
        tick();
        check_eq("b2b_st", 32'(word_a()), 32'(WSt));
        drive_a(1'b0, 5'h00);
        tick();
        check_eq("idle_hold", 32'(word_a()), 32'(WIdle));

        // MAC with MUL_LAT=3; ADD waits from cycle 1 until accepted in cycle 3.
        drive_a(1'b1, 5'h04);
        tick();
        check_eq("mac_c1_rdy", 32'(bus_a.instr_ready), 32'd0);
        check_eq("mac_c1_word", 32'(word_a()), 32'(WMacW));
        drive_a(1'b1, 5'h01);
        tick();
        check_eq("mac_c2_rdy", 32'(bus_a.instr_ready), 32'd0);
        check_eq("mac_c2_word", 32'(word_a()), 32'(WMacW));
        tick();
        check_eq("mac_c3_rdy", 32'(bus_a.instr_ready), 32'd1);
        check_eq("mac_c3_word", 32'(word_a()), 32'(WMac));
        tick();
        check_eq("mac_add_c4", 32'(word_a()), 32'(WAdd));
        drive_a(1'b0, 5'h00);
        tick();
        check_eq("mac_after", 32'(bus_a.ctrl_valid), 32'd0);

        // Undefined opcodes: 5, then 9 with bit 4 set.
        drive_a(1'b1, 5'h05);
        tick();
        check_eq("ill1_pulse", 32'(bus_a.illegal), 32'd1);
        check_eq("ill1_word", 32'(word_a()), 32'(WNop));
        check_eq("ill1_cnt", 32'(bus_a.err_cnt), 32'd1);
        drive_a(1'b1, 5'h19);
        tick();
        check_eq("ill2_pulse", 32'(bus_a.illegal), 32'd1);
        check_eq("ill2_word", 32'(word_a()), 32'(WNop));
        check_eq("ill2_cnt", 32'(bus_a.err_cnt), 32'd2);
        drive_a(1'b0, 5'h00);
        tick();
        check_eq("ill_drop", 32'(bus_a.illegal), 32'd0);
        check_eq("ill_cnt_hold", 32'(bus_a.err_cnt), 32'd2);

        // 258 more undefined opcodes (260 total) saturate the counter.
        for (int i = 0; i < 258; i++) begin
            drive_a(1'b1, 5'h10);
            tick();
            if (i == 252) begin
                check_eq("sat_cnt_255", 32'(bus_a.err_cnt), 32'd255);
            end
        end
        drive_a(1'b0, 5'h00);
        check_eq("sat_cnt_final", 32'(bus_a.err_cnt), 32'd255);
        check_eq("sat_ill_pulse", 32'(bus_a.illegal), 32'd1);

        // HALT then ADD: ADD is ignored until reset.
        drive_a(1'b1, 5'h0B);
        tick();
        check_eq("halt_word", 32'(word_a()), 32'(WNop));
        check_eq("halt_flag", 32'(bus_a.halted), 32'd1);
        check_eq("halt_rdy", 32'(bus_a.instr_ready), 32'd0);
        drive_a(1'b1, 5'h01);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("halt_no_cv", 32'(bus_a.ctrl_valid), 32'd0);
            check_eq("halt_sticky", {30'd0, bus_a.halted, bus_a.instr_ready}, 32'h2);
        end
        drive_a(1'b0, 5'h00);
        rst_n = 1'b0;
        #1;
        check_eq("halt_rst_flag", 32'(bus_a.halted), 32'd0);
        check_eq("halt_rst_cnt", 32'(bus_a.err_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        check_eq("halt_rst_rdy", 32'(bus_a.instr_ready), 32'd1);

        // MUL with MUL_LAT=4 completes in cycle 4.
        bus_b.instr_valid = 1'b1;
        bus_b.opcode      = 4'h2;
        tick();
        bus_b.instr_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            check_eq("mul4_wait_cv", {30'd0, bus_b.ctrl_valid, bus_b.instr_ready}, 32'h0);
            tick();
        end
        check_eq("mul4_done", 32'(word_b()), 32'(WMul));
        check_eq("mul4_rdy", 32'(bus_b.instr_ready), 32'd1);
        tick();

        // Reset in cycle 1 of a MUL_LAT=4 MUL: no RegWrite ever appears.
        bus_b.instr_valid = 1'b1;
        bus_b.opcode      = 4'h2;
        tick();
        bus_b.instr_valid = 1'b0;
        check_eq("mulrst_c1_rdy", 32'(bus_b.instr_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("mulrst_word", 32'(word_b()), 32'(WRst));
        check_eq("mulrst_flags", {29'd0, bus_b.halted, bus_b.illegal, bus_b.instr_ready},
                 32'h1);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("mulrst_no_rw", {30'd0, bus_b.RegWrite, bus_b.ctrl_valid}, 32'h0);
        end
        check_eq("mulrst_final", 32'(word_b()), 32'(WRst));
        check_eq("mulrst_cnt", 32'(bus_b.err_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
